// File: rtl/prime_pkg.sv
// Shared definitions for the prime range scanner.
//   DEFAULT_WIDTH : default operand width of range bounds and issued numbers
//   state_e       : 2-bit scanner state encoding
package prime_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/prime_range_scanner.sv
// Prime range scanner: walks every number in [lo, hi], hands each candidate
// >= 2 to an external prime checker over a valid/ready request channel,
// collects the checker's verdicts, and reports the prime count and the
// largest prime seen on a valid/ready summary channel.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   valid_i/ready_i, lo, hi          command channel (range, inclusive)
//   chk_valid/chk_ready, chk_number  checker request channel
//   chk_res_valid/chk_res_ready,
//   chk_result                       checker response channel (1 = prime)
//   valid_o/ready_o, prime_count,
//   largest_prime                    summary channel
//
// State | meaning
// IDLE   | waiting for a command, ready_i high
// ISSUE  | presenting cur to the checker (numbers < 2 skipped here)
// WAIT   | one request outstanding, waiting for its verdict
// REPORT | summary held on valid_o until ready_o
module prime_range_scanner
  import prime_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_i,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             chk_valid,
  input  logic             chk_ready,
  output logic [WIDTH-1:0] chk_number,
  input  logic             chk_res_valid,
  output logic             chk_res_ready,
  input  logic             chk_result,
  output logic             valid_o,
  input  logic             ready_o,
  output logic [CNT_W-1:0] prime_count,
  output logic [WIDTH-1:0] largest_prime
);

  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] largest_q, largest_d;
  logic             advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      hi_q      <= '0;
      count_q   <= '0;
      largest_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      hi_q      <= hi_d;
      count_q   <= count_d;
      largest_q <= largest_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    hi_d      = hi_q;
    count_d   = count_q;
    largest_d = largest_q;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          hi_d      = hi;
          cur_d     = lo;
          count_d   = '0;
          largest_d = '0;
          // An empty range needs no checker traffic at all.
          state_d   = (lo > hi) ? ST_REPORT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_q < TWO) begin
          advance = 1'b1;
        end else if (chk_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (chk_res_valid) begin
          if (chk_result) begin
            count_d   = count_q + CNT_W'(1);
            largest_d = cur_q;
          end
          advance = 1'b1;
        end
      end
      ST_REPORT: begin
        if (ready_o) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stop on hi before incrementing so an all-ones hi never wraps cur to 0.
    if (advance) begin
      if (cur_q == hi_q) begin
        state_d = ST_REPORT;
      end else begin
        cur_d   = cur_q + WIDTH'(1);
        state_d = ST_ISSUE;
      end
    end
  end

  assign ready_i       = (state_q == ST_IDLE);
  assign chk_valid     = (state_q == ST_ISSUE) && (cur_q >= TWO);
  assign chk_number    = cur_q;
  assign chk_res_ready = (state_q == ST_WAIT);
  assign valid_o       = (state_q == ST_REPORT);
  assign prime_count   = count_q;
  assign largest_prime = largest_q;

endmodule

// File: tb/tb_prime_range_scanner.sv
// Directed testbench for prime_range_scanner with a behavioural prime
// checker on the chk_* channels.
module tb_prime_range_scanner;

  localparam int W  = 16;
  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_i;
  logic [W-1:0]  lo = '0;
  logic [W-1:0]  hi = '0;
  logic          chk_valid;
  logic          chk_ready;
  logic [W-1:0]  chk_number;
  logic          chk_res_valid;
  logic          chk_res_ready;
  logic          chk_result;
  logic          valid_o;
  logic          ready_o = 1'b0;
  logic [CW-1:0] prime_count;
  logic [W-1:0]  largest_prime;

  int checks = 0;
  int failures = 0;

  bit           pending = 1'b0;
  logic [W-1:0] pending_num = '0;
  int           req_count = 0;
  bit           stall_mode = 1'b0;
  bit           hold_resp = 1'b0;
  bit           inject = 1'b0;

  prime_range_scanner #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_i(valid_i), .ready_i(ready_i), .lo(lo), .hi(hi),
    .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_number(chk_number),
    .chk_res_valid(chk_res_valid), .chk_res_ready(chk_res_ready),
    .chk_result(chk_result),
    .valid_o(valid_o), .ready_o(ready_o),
    .prime_count(prime_count), .largest_prime(largest_prime)
  );

  always #5 clk = ~clk;

  function automatic bit is_prime(input int n);
    if (n < 2) return 1'b0;
    for (int d = 2; d * d <= n; d++) begin
      if (n % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Track checker handshakes as seen on the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
    end else begin
      if (chk_valid && chk_ready) begin
        req_count++;
        pending     = 1'b1;
        pending_num = chk_number;
      end
      if (chk_res_valid && chk_res_ready) pending = 1'b0;
    end
  end

  // Behavioural checker: drives its inputs just after each rising edge.
  initial begin
    chk_ready     = 1'b0;
    chk_res_valid = 1'b0;
    chk_result    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      chk_ready     = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      chk_res_valid = inject || (pending && !hold_resp &&
                      (stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1));
      chk_result    = is_prime(int'(pending_num));
    end
  end

  task automatic run_cmd(input logic [W-1:0] l, input logic [W-1:0] h,
                         output int cyc, output logic [CW-1:0] cnt,
                         output logic [W-1:0] lg, output int reqs);
    int           base;
    bit           st_prev;
    logic [W-1:0] num_prev;
    @(negedge clk);
    base    = req_count;
    valid_i = 1'b1;
    lo      = l;
    hi      = h;
    @(negedge clk);
    valid_i  = 1'b0;
    cyc      = 1;
    st_prev  = 1'b0;
    num_prev = '0;
    while (valid_o !== 1'b1 && cyc < 3000) begin
      if (st_prev) chk("chk_number_stable", {chk_valid, chk_number}, {1'b1, num_prev});
      st_prev  = chk_valid && !chk_ready;
      num_prev = chk_number;
      @(negedge clk);
      cyc++;
    end
    chk("report_reached", valid_o, 1);
    cnt  = prime_count;
    lg   = largest_prime;
    reqs = req_count - base;
    if (stall_mode) begin
      repeat (int'($urandom_range(1, 4))) begin
        ready_o = 1'b0;
        @(negedge clk);
        chk("report_hold", {valid_o, prime_count, largest_prime}, {1'b1, cnt, lg});
      end
    end
    ready_o = 1'b1;
    @(negedge clk);
    ready_o = 1'b0;
    chk("back_to_idle", {valid_o, ready_i}, 2'b01);
  endtask

  initial begin
    int            cyc;
    int            reqs;
    int            n;
    logic [CW-1:0] cnt;
    logic [W-1:0]  lg;

    #1;
    chk("rst_ready_i", ready_i, 1);
    chk("rst_chk_valid", chk_valid, 0);
    chk("rst_chk_res_ready", chk_res_ready, 0);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_prime_count", prime_count, 0);
    chk("rst_largest", largest_prime, 0);
    chk("rst_chk_number", chk_number, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_cmd(16'd2, 16'd10, cyc, cnt, lg, reqs);
    chk("r2_10_count", cnt, 4);
    chk("r2_10_largest", lg, 7);
    chk("r2_10_reqs", reqs, 9);
    chk("r2_10_cycles", cyc, 19);

    run_cmd(16'd0, 16'd1, cyc, cnt, lg, reqs);
    chk("r0_1_count", cnt, 0);
    chk("r0_1_largest", lg, 0);
    chk("r0_1_reqs", reqs, 0);
    chk("r0_1_cycles", cyc, 3);

    run_cmd(16'd10, 16'd5, cyc, cnt, lg, reqs);
    chk("rev_count", cnt, 0);
    chk("rev_largest", lg, 0);
    chk("rev_reqs", reqs, 0);
    chk("rev_cycles", cyc, 1);

    run_cmd(16'd7, 16'd7, cyc, cnt, lg, reqs);
    chk("r7_count", cnt, 1);
    chk("r7_largest", lg, 7);
    chk("r7_reqs", reqs, 1);
    chk("r7_cycles", cyc, 3);

    run_cmd(16'd65520, 16'd65535, cyc, cnt, lg, reqs);
    chk("top_count", cnt, 1);
    chk("top_largest", lg, 65521);
    chk("top_reqs", reqs, 16);
    chk("top_cycles", cyc, 33);

    stall_mode = 1'b1;
    run_cmd(16'd2, 16'd10, cyc, cnt, lg, reqs);
    chk("stall_count", cnt, 4);
    chk("stall_largest", lg, 7);
    chk("stall_reqs", reqs, 9);
    stall_mode = 1'b0;

    // Reset while a checker request is outstanding.
    hold_resp = 1'b1;
    @(negedge clk);
    valid_i = 1'b1;
    lo      = 16'd2;
    hi      = 16'd100;
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (chk_res_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_in_wait", chk_res_ready, 1);
    chk("mid_ready_i_busy", ready_i, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready_i", ready_i, 1);
    chk("mid_rst_chk_valid", chk_valid, 0);
    chk("mid_rst_chk_res_ready", chk_res_ready, 0);
    chk("mid_rst_valid_o", valid_o, 0);
    chk("mid_rst_prime_count", prime_count, 0);
    chk("mid_rst_largest", largest_prime, 0);
    chk("mid_rst_chk_number", chk_number, 0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    hold_resp = 1'b0;
    inject    = 1'b1;
    repeat (3) @(negedge clk);
    inject = 1'b0;
    chk("late_resp_ready_i", ready_i, 1);
    chk("late_resp_valid_o", valid_o, 0);
    chk("late_resp_chk_res_ready", chk_res_ready, 0);
    chk("late_resp_count", prime_count, 0);
    @(negedge clk);

    run_cmd(16'd2, 16'd10, cyc, cnt, lg, reqs);
    chk("post_rst_count", cnt, 4);
    chk("post_rst_largest", lg, 7);
    chk("post_rst_reqs", reqs, 9);
    chk("post_rst_cycles", cyc, 19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prime_range_scanner.md
PRIME_RANGE_SCANNER -- requirements
Module: prime_range_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width of range bounds and issued numbers.
REQ-002 SHALL have parameter CNT_W, default WIDTH+1, giving the prime-count width, sized to hold 2^WIDTH without overflow.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock), then rst_n input 1 (async active-low reset).
REQ-004 SHALL have these command ports: valid_i input 1 (command valid); ready_i output 1 (command accepted when high); lo input WIDTH (first number); hi input WIDTH (last number, inclusive).
REQ-005 SHALL have these checker request ports: chk_valid output 1; chk_ready input 1; chk_number output WIDTH (number to test).
REQ-006 SHALL have these checker response ports: chk_res_valid input 1; chk_res_ready output 1; chk_result input 1 (1 = prime).
REQ-007 SHALL have these summary ports: valid_o output 1; ready_o input 1; prime_count output CNT_W; largest_prime output WIDTH (0 if no prime found).

Function
REQ-008 SHALL transfer data on any interface only in a cycle where both valid and ready are high on a rising clk edge.
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, REPORT, with state encoding 2 bits.
REQ-010 IDLE: ready_i=1; on a valid_i transfer, SHALL register lo and hi, set cur=lo, clear prime_count and largest_prime, and go to ISSUE next cycle.
REQ-011 IDLE with lo>hi: SHALL go directly to REPORT with prime_count=0 and largest_prime=0, and SHALL NOT assert chk_valid.
REQ-012 ISSUE with cur<2: SHALL skip the number without asserting chk_valid, treat it as non-prime, and apply the REQ-015 advance rule in the same cycle.
REQ-013 ISSUE with cur>=2: chk_valid=1 and chk_number=cur, held stable until the chk_ready transfer; after the transfer, SHALL go to WAIT.
REQ-014 WAIT: chk_res_ready=1; on a chk_res_valid transfer, if chk_result=1 SHALL increment prime_count and set largest_prime=cur; SHALL then apply REQ-015.
REQ-015 Advance rule: if cur==hi, SHALL go to REPORT; otherwise SHALL set cur=cur+1 and go to ISSUE; no increment SHALL occur when cur==hi, so hi=2^WIDTH-1 never wraps.
REQ-016 REPORT: valid_o=1, with prime_count and largest_prime held stable; on a ready_o transfer, SHALL go to IDLE; ready_o low SHALL hold REPORT indefinitely.
REQ-017 SHALL keep at most one checker request outstanding; chk_res_valid arriving outside WAIT SHALL be ignored (chk_res_ready=0).
REQ-018 Minimum per-number latency SHALL be ISSUE 1 cycle + WAIT 1 cycle when the checker responds immediately; the skip path of REQ-012 SHALL take 1 cycle.
REQ-019 ready_i SHALL be 0 in every state except IDLE; a command presented mid-scan SHALL be held off, not dropped.
REQ-020 All outputs SHALL be driven from registers or from state decode only, with no combinational path from chk_ready, chk_res_valid or ready_o to any output.

Reset
REQ-021 On rst_n low, asynchronously: state=IDLE, ready_i=1, chk_valid=0, chk_res_ready=0, valid_o=0, prime_count=0, largest_prime=0, chk_number=0, cur=0.
REQ-022 Reset asserted mid-scan SHALL abandon the scan with no summary produced; any checker response arriving after reset release while in IDLE SHALL be ignored.

Structure
REQ-023 A shared package prime_pkg SHALL hold the scanner state encoding constants and the default WIDTH; no typedefs beyond those SHALL be required.
REQ-024 No sub-module SHALL be instantiated; the prime checker stage is connected externally through the chk_* ports.

Verification
REQ-025 lo=2, hi=10, with a real checker attached: exactly 9 checker requests (2..10); the summary SHALL report prime_count=4, largest_prime=7.
REQ-026 lo=0, hi=1: chk_valid SHALL never assert; REPORT SHALL be reached within 3 cycles of the command, with prime_count=0, largest_prime=0.
REQ-027 lo=10, hi=5: REPORT SHALL be reached on the cycle after command acceptance, with count=0 and zero checker requests.
REQ-028 WIDTH=16, lo=65520, hi=65535: the scan SHALL terminate with prime_count=1 and largest_prime=65521, and cur SHALL never wrap to 0.
REQ-029 Range 2..10 with chk_ready, chk_res_valid and ready_o randomly low: the summary SHALL be unchanged (4, 7); chk_number SHALL be stable while stalled; valid_o SHALL stay high with stable data until ready_o.
REQ-030 Assert rst_n low while in WAIT during a 2..100 scan: all outputs SHALL be at reset values immediately; a late chk_res_valid pulse SHALL be ignored; a new 2..10 command SHALL then report 4, 7.
